// File: rtl/ctrl_decoder.sv
// Hardwired control unit: beat/opcode decode to datapath strobes,
// run-control FSM and sticky timing-fault monitor.
module ctrl_decoder #(
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] HLT_OP = '1
) (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic [7:0] T,
  input  logic       RUN_EN,
  input  logic [7:0] DIN,
  input  logic       ZF,
  input  logic       CF,
  output logic       MAR_LD,
  output logic       ADDR_SEL,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic       ACC_LD,
  output logic [1:0] ALU_OP,
  output logic       FLAG_LD,
  output logic       HALT,
  output logic       T_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [OPW-1:0] opc;
  logic [7-OPW:0] opd;
  logic           zf_s;
  logic           cf_s;
  logic           err;
  logic           onehot;
  logic           run;
  logic           is_mem;
  logic           unused;

  assign onehot = (T != 8'h00) &&
                  ((T & (T - 8'd1)) == 8'h00);
  assign run    = (state == S_RUN) && onehot;
  assign unused = ^opd;

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state <= S_IDLE;
      opc   <= '0;
      opd   <= '0;
      zf_s  <= 1'b0;
      cf_s  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (!onehot)
        err <= 1'b1;
      if (run && T[1])
        {opc, opd} <= DIN;
      if (run && T[2]) begin
        zf_s <= ZF;
        cf_s <= CF;
      end
    end
  end

  // A malformed beat overrides every other transition
  always_comb begin
    nxt = state;
    if (!onehot) begin
      nxt = S_HALT;
    end else begin
      case (state)
        S_IDLE:
          if (T[7] && RUN_EN)
            nxt = S_RUN;
        S_RUN:
          if (T[2] && opc == HLT_OP)
            nxt = S_HALT;
          else if (T[7] && !RUN_EN)
            nxt = S_IDLE;
        default:
          nxt = S_HALT;
      endcase
    end
  end

  always_comb begin
    is_mem = (opc == OPW'(1)) || (opc == OPW'(2)) ||
             (opc == OPW'(3)) || (opc == OPW'(4));
  end

  always_comb begin
    MAR_LD   = 1'b0;
    ADDR_SEL = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    IR_LD    = 1'b0;
    PC_INC   = 1'b0;
    PC_LD    = 1'b0;
    ACC_LD   = 1'b0;
    ALU_OP   = 2'b00;
    FLAG_LD  = 1'b0;
    if (run) begin
      unique case (1'b1)
        T[0]: MAR_LD = 1'b1;
        T[1]: begin
          MEM_RD = 1'b1;
          IR_LD  = 1'b1;
          PC_INC = 1'b1;
        end
        T[2]: if (is_mem) begin
          MAR_LD   = 1'b1;
          ADDR_SEL = 1'b1;
        end
        T[3]: begin
          case (opc)
            OPW'(1): begin
              MEM_RD = 1'b1;
              ACC_LD = 1'b1;
            end
            OPW'(2): MEM_WR = 1'b1;
            OPW'(3): begin
              MEM_RD  = 1'b1;
              ACC_LD  = 1'b1;
              ALU_OP  = 2'b01;
              FLAG_LD = 1'b1;
            end
            OPW'(4): begin
              MEM_RD  = 1'b1;
              ACC_LD  = 1'b1;
              ALU_OP  = 2'b10;
              FLAG_LD = 1'b1;
            end
            OPW'(5): PC_LD = 1'b1;
            OPW'(6): PC_LD = zf_s;
            OPW'(7): PC_LD = cf_s;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign HALT  = (state == S_HALT);
  assign T_ERR = err;

endmodule
